// File: rtl/viterbi_sched.sv
// Viterbi decode sequencer: symbol intake to the BMU, ACS strobe/normalise scheduling, traceback windowing.
// Optional VIT_SCHED_STATS_EN adds sym_count/stall_count outputs and the stats_clr input.
module viterbi_sched #(
  parameter int SYM_W   = 8,
  parameter int BMU_LAT = 1,
  parameter int ACS_LAT = 2,
  parameter int TB_LEN  = 64
) (
  input  logic                          clk,
  input  logic                          sys_rst_n,
  input  logic                          en,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [SYM_W-1:0]              s_i,
  input  logic [SYM_W-1:0]              s_q,
  input  logic                          flush,
  output logic [SYM_W-1:0]              bmu_i,
  output logic [SYM_W-1:0]              bmu_q,
  output logic                          acs_en,
  input  logic                          acs_norm_req,
  output logic                          acs_norm,
  output logic                          tb_start,
  output logic [$clog2(TB_LEN+1)-1:0]   tb_len,
  input  logic                          tb_done,
`ifdef VIT_SCHED_STATS_EN
  input  logic                          stats_clr,
  output logic [31:0]                   sym_count,
  output logic [31:0]                   stall_count,
`endif
  output logic                          busy
);

  localparam int LW = $clog2(TB_LEN+1);
  localparam int DW = $clog2(BMU_LAT+ACS_LAT+2);
  localparam int NW = $clog2(ACS_LAT+2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, TB} state_t;

  state_t              state_r, state_s;
  logic [LW-1:0]       win_cnt_r, win_inc_s;
  logic [DW-1:0]       drain_cnt_r;
  logic [NW-1:0]       blk_cnt_r;
  logic [BMU_LAT-1:0]  pipe_r;
  logic                pend_r;
  logic                hs_s, launch_s, req_ok_s, norm_hit_s;

  // Next-state decode and strobe qualifiers
  always_comb begin
    hs_s       = s_valid && s_ready;
    win_inc_s  = win_cnt_r + LW'(1);
    state_s    = state_r;
    launch_s   = 1'b0;
    req_ok_s   = acs_norm_req && (blk_cnt_r == NW'(0));
    norm_hit_s = pipe_r[BMU_LAT-1] && (pend_r || req_ok_s);
    case (state_r)
      IDLE: begin
        if (en) state_s = RUN;
        else    state_s = IDLE;
      end
      RUN: begin
        // A flush that coincides with a handshake still closes the window after counting it.
        if (hs_s && (win_inc_s == LW'(TB_LEN)))            state_s = DRAIN;
        else if (flush && (hs_s || (win_cnt_r != LW'(0)))) state_s = DRAIN;
        else                                               state_s = RUN;
      end
      DRAIN: begin
        if (drain_cnt_r == DW'(1)) begin
          state_s  = TB;
          launch_s = 1'b1;
        end else begin
          state_s  = DRAIN;
        end
      end
      TB: begin
        if (tb_done && !tb_start) state_s = en ? RUN : IDLE;
        else                      state_s = TB;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r     <= IDLE;
      win_cnt_r   <= '0;
      drain_cnt_r <= '0;
      blk_cnt_r   <= '0;
      pipe_r      <= '0;
      pend_r      <= 1'b0;
      s_ready     <= 1'b0;
      busy        <= 1'b0;
      bmu_i       <= '0;
      bmu_q       <= '0;
      acs_en      <= 1'b0;
      acs_norm    <= 1'b0;
      tb_start    <= 1'b0;
      tb_len      <= '0;
    end else begin
      state_r  <= state_s;
      s_ready  <= (state_s == RUN) && en;
      busy     <= (state_s != IDLE);
      tb_start <= launch_s;

      if (launch_s)  win_cnt_r <= '0;
      else if (hs_s) win_cnt_r <= win_inc_s;

      if (launch_s) tb_len <= win_cnt_r;

      // Drain covers the BMU and ACS latency of the last accepted symbol.
      if ((state_r == RUN) && (state_s == DRAIN)) drain_cnt_r <= DW'(BMU_LAT+ACS_LAT+1);
      else if (drain_cnt_r != DW'(0))             drain_cnt_r <= drain_cnt_r - DW'(1);

      if (hs_s) begin
        bmu_i <= s_i;
        bmu_q <= s_q;
      end

      pipe_r[0] <= hs_s;
      for (int k = 1; k < BMU_LAT; k++) pipe_r[k] <= pipe_r[k-1];
      acs_en   <= pipe_r[BMU_LAT-1];
      acs_norm <= norm_hit_s;

      // Requests are masked while the previous subtract propagates through the ACS.
      if (norm_hit_s)                   blk_cnt_r <= NW'(ACS_LAT+1);
      else if (blk_cnt_r != NW'(0))     blk_cnt_r <= blk_cnt_r - NW'(1);

      if (launch_s)        pend_r <= 1'b0;
      else if (norm_hit_s) pend_r <= 1'b0;
      else if (req_ok_s)   pend_r <= 1'b1;
    end
  end

`ifdef VIT_SCHED_STATS_EN
  // Accepted-symbol (wrapping) and stall (saturating) counters
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sym_count   <= 32'd0;
      stall_count <= 32'd0;
    end else if (stats_clr) begin
      sym_count   <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (hs_s) sym_count <= sym_count + 32'd1;
      if (s_valid && !s_ready && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_viterbi_sched.sv
// Randomized self-checking bench for viterbi_sched against a cycle-scheduled reference model.
// Build with VIT_SCHED_STATS_EN defined to also check the statistics counters.
module tb_viterbi_sched;
  localparam int SYM_W   = 8;
  localparam int BMU_LAT = 1;
  localparam int ACS_LAT = 2;
  localparam int TB_LEN  = 4;
  localparam int LW      = $clog2(TB_LEN+1);

  logic clk = 1'b0, sys_rst_n = 1'b1, en = 1'b0, s_valid = 1'b0, flush = 1'b0;
  logic acs_norm_req = 1'b0, tb_done = 1'b0;
  logic [SYM_W-1:0] s_i = '0, s_q = '0;
  logic s_ready, acs_en, acs_norm, tb_start, busy;
  logic [SYM_W-1:0] bmu_i, bmu_q;
  logic [LW-1:0] tb_len;
`ifdef VIT_SCHED_STATS_EN
  logic stats_clr = 1'b0;
  logic [31:0] sym_count, stall_count;
`endif

  always #5 clk = ~clk;

  viterbi_sched #(.SYM_W(SYM_W), .BMU_LAT(BMU_LAT), .ACS_LAT(ACS_LAT), .TB_LEN(TB_LEN)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .en(en), .s_valid(s_valid), .s_ready(s_ready),
    .s_i(s_i), .s_q(s_q), .flush(flush), .bmu_i(bmu_i), .bmu_q(bmu_q),
    .acs_en(acs_en), .acs_norm_req(acs_norm_req), .acs_norm(acs_norm),
    .tb_start(tb_start), .tb_len(tb_len), .tb_done(tb_done),
`ifdef VIT_SCHED_STATS_EN
    .stats_clr(stats_clr), .sym_count(sym_count), .stall_count(stall_count),
`endif
    .busy(busy));

  int n_cmp = 0, n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: cycle cyc ends at each posedge; acs_sched holds cycles with a due ACS strobe.
  int cyc = 0, phase = 0, win = 0, tb_at = -1, launch_cyc = -1, last_norm = -100;
  bit pend = 1'b0;
  bit acs_sched [0:8191];
  logic e_ready = 1'b0, e_acs = 1'b0, e_norm = 1'b0, e_tbs = 1'b0, e_busy = 1'b0;
  logic [SYM_W-1:0] e_bi = '0, e_bq = '0;
  logic [LW-1:0] e_tblen = '0;
  logic [31:0] e_sym = 32'd0, e_stall = 32'd0;

  always @(posedge clk) begin : ref_model
    bit hs, nxt_acs, elig, tbs;
    int nph;
    if (!sys_rst_n) begin
      phase = 0; win = 0; tb_at = -1; launch_cyc = -1; last_norm = -100; pend = 1'b0;
      e_ready = 1'b0; e_acs = 1'b0; e_norm = 1'b0; e_tbs = 1'b0; e_busy = 1'b0;
      e_bi = '0; e_bq = '0; e_tblen = '0; e_sym = 32'd0; e_stall = 32'd0;
      for (int k = 0; k < 16; k++) acs_sched[(cyc+k) % 8192] = 1'b0;
    end else begin
      hs = s_valid && e_ready;
      nph = phase;
      tbs = 1'b0;
`ifdef VIT_SCHED_STATS_EN
      if (stats_clr) begin
        e_sym = 32'd0; e_stall = 32'd0;
      end else begin
        if (hs) e_sym = e_sym + 32'd1;
        if (s_valid && !e_ready && e_stall != 32'hFFFF_FFFF) e_stall = e_stall + 32'd1;
      end
`endif
      case (phase)
        0: if (en) nph = 1;
        1: begin
          if (hs) begin
            win++;
            acs_sched[(cyc+1+BMU_LAT) % 8192] = 1'b1;
            e_bi = s_i; e_bq = s_q;
          end
          if (win == TB_LEN || (flush && win > 0)) begin
            nph = 2;
            tb_at = cyc + 2 + BMU_LAT + ACS_LAT;
          end
        end
        2: if (cyc + 1 == tb_at) begin
          nph = 3; e_tblen = LW'(win); win = 0; tbs = 1'b1; launch_cyc = cyc + 1;
        end
        3: if (tb_done && cyc != launch_cyc) nph = en ? 1 : 0;
        default: nph = 0;
      endcase
      nxt_acs = acs_sched[(cyc+1) % 8192];
      acs_sched[(cyc+1) % 8192] = 1'b0;
      elig = acs_norm_req && (cyc >= last_norm + ACS_LAT + 1);
      if (nxt_acs && (pend || elig)) begin
        e_norm = 1'b1; pend = 1'b0; last_norm = cyc + 1;
      end else begin
        e_norm = 1'b0;
        if (elig) pend = 1'b1;
      end
      if (tbs) pend = 1'b0;
      e_acs = nxt_acs; e_tbs = tbs;
      e_ready = (nph == 1) && en;
      e_busy = (nph != 0);
      phase = nph;
    end
    cyc++;
  end

  bit chk_on = 1'b0;
  int last_seen_norm = -1;

  // Compare every output against the model in the middle of each cycle.
  always @(negedge clk) begin
    if (!sys_rst_n) last_seen_norm = -1;
    else if (chk_on) begin
      check_val("s_ready", s_ready, e_ready);
      check_val("bmu_i", bmu_i, e_bi);
      check_val("bmu_q", bmu_q, e_bq);
      check_val("acs_en", acs_en, e_acs);
      check_val("acs_norm", acs_norm, e_norm);
      check_val("tb_start", tb_start, e_tbs);
      check_val("tb_len", tb_len, e_tblen);
      check_val("busy", busy, e_busy);
`ifdef VIT_SCHED_STATS_EN
      check_val("sym_count", sym_count, e_sym);
      check_val("stall_count", stall_count, e_stall);
`endif
      if (acs_norm) begin
        check_val("norm_needs_en", acs_en, 1);
        if (last_seen_norm >= 0) check_val("norm_gap", (cyc - last_seen_norm) >= ACS_LAT + 2, 1);
        last_seen_norm = cyc;
      end
    end
  end

  // Traceback unit stand-in; a zero delay also exercises the same-cycle tb_done rule.
  initial begin : tb_responder
    int d;
    forever begin
      @(negedge clk);
      if (tb_start && sys_rst_n) begin
        d = $urandom_range(0, 5);
        if (d == 0) begin
          tb_done = 1'b1;
          @(negedge clk);
          tb_done = 1'b0;
          d = 3;
        end
        repeat (d) @(negedge clk);
        tb_done = 1'b1;
        @(negedge clk);
        tb_done = 1'b0;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_val({tag, "_s_ready"}, s_ready, 0);
    check_val({tag, "_acs_en"}, acs_en, 0);
    check_val({tag, "_acs_norm"}, acs_norm, 0);
    check_val({tag, "_tb_start"}, tb_start, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_bmu_i"}, bmu_i, 0);
    check_val({tag, "_bmu_q"}, bmu_q, 0);
    check_val({tag, "_tb_len"}, tb_len, 0);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    flush = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [SYM_W-1:0] i, input logic [SYM_W-1:0] q);
    logic r;
    bit done = 1'b0;
    s_valid = 1'b1; s_i = i; s_q = q;
    for (int k = 0; k < 200 && !done; k++) begin
      r = s_ready;
      @(negedge clk);
      done = r;
    end
    if (!done) check_val("handshake_timeout", 0, 1);
    s_valid = 1'b0;
  endtask

  initial begin : driver
    int tbs_seen;
    #1 sys_rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #2 sys_rst_n = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    en = 1'b1;
    idle(3);
    send(8'hFF, 8'h00);
    idle(6);
    for (int k = 0; k < TB_LEN; k++) send(SYM_W'($urandom), SYM_W'($urandom));
    idle(20);
    for (int k = 0; k < 3; k++) send(SYM_W'($urandom), SYM_W'($urandom));
    idle(2);
    flush = 1'b1;
    @(negedge clk);
    idle(20);
    flush = 1'b1;
    @(negedge clk);
    idle(6);
    acs_norm_req = 1'b1;
    for (int k = 0; k < 8; k++) send(SYM_W'($urandom), SYM_W'($urandom));
    idle(20);
    acs_norm_req = 1'b0;
    for (int k = 0; k < TB_LEN; k++) send(SYM_W'(k + 1), SYM_W'(k + 9));
    s_valid = 1'b1; s_i = 8'hAA; s_q = 8'h55;
    repeat (12) @(negedge clk);
    idle(20);
    send(8'h11, 8'h22);
    send(8'h33, 8'h44);
    @(posedge clk);
    #2 sys_rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (2) @(posedge clk);
    #2 sys_rst_n = 1'b1;
    tbs_seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (tb_start) tbs_seen++;
    end
    check_val("no_tb_after_reset", tbs_seen, 0);
`ifdef VIT_SCHED_STATS_EN
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
`endif
    for (int k = 0; k < 1500; k++) begin
      en = ($urandom_range(0, 19) != 0);
      s_valid = ($urandom_range(0, 3) != 0);
      s_i = SYM_W'($urandom);
      s_q = SYM_W'($urandom);
      flush = en && ($urandom_range(0, 15) == 0);
      acs_norm_req = ($urandom_range(0, 3) == 0);
`ifdef VIT_SCHED_STATS_EN
      stats_clr = ($urandom_range(0, 99) == 0);
`endif
      @(negedge clk);
    end
    en = 1'b1;
    acs_norm_req = 1'b0;
`ifdef VIT_SCHED_STATS_EN
    stats_clr = 1'b0;
`endif
    idle(30);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    check_val("watchdog", 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
